// File: rtl/demux3_stream.sv
// demux3_stream: 2-entry stream FIFO whose head word is steered to one of
// three destination channels according to the select stored with it.
// Words with select 2'b11 are dropped (and counted) instead of delivered.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. in_ready depends only on registered state. A y*_valid never
// depends on any y*_ready. Once raised, it holds with stable data until its
// transfer completes.
module demux3_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic             y0_valid,
  output logic             y1_valid,
  output logic             y2_valid,
  input  logic             y0_ready,
  input  logic             y1_ready,
  input  logic             y2_ready,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic             err_sel,
  output logic [7:0]       drop_cnt
);

  // Each entry stores {sel, data}
  logic [WIDTH+1:0] mem_q [2];
  logic [WIDTH+1:0] mem_d [2];
  logic [1:0]       count_q, count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             err_sel_q, err_sel_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic [WIDTH+1:0] head;
  logic [1:0]       head_sel;
  logic [WIDTH-1:0] head_data;
  logic             non_empty;
  logic             sel_ready;
  logic             push;
  logic             pop;

  // Head decode, handshake qualifiers and channel outputs
  always_comb begin
    head      = mem_q[rd_ptr_q];
    head_sel  = head[WIDTH+1:WIDTH];
    head_data = head[WIDTH-1:0];
    non_empty = (count_q != 2'd0);
    in_ready  = (count_q < 2'd2);
    push      = in_valid && in_ready;
    sel_ready = 1'b0;
    case (head_sel)
      2'd0:    sel_ready = y0_ready;
      2'd1:    sel_ready = y1_ready;
      2'd2:    sel_ready = y2_ready;
      default: sel_ready = 1'b1;  // invalid select: drop without waiting
    endcase
    pop      = non_empty && sel_ready;
    y0_valid = non_empty && (head_sel == 2'd0);
    y1_valid = non_empty && (head_sel == 2'd1);
    y2_valid = non_empty && (head_sel == 2'd2);
    y0       = non_empty ? head_data : '0;
    y1       = non_empty ? head_data : '0;
    y2       = non_empty ? head_data : '0;
    err_sel  = err_sel_q;
    drop_cnt = drop_cnt_q;
  end

  // Next-state: storage write, pointer advance, occupancy, error/drop tracking
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    err_sel_d  = err_sel_q;
    drop_cnt_d = drop_cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = {in_sel, in_data};
      wr_ptr_d        = ~wr_ptr_q;
      if (in_sel == 2'd3) begin
        err_sel_d = 1'b1;
      end
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      if ((head_sel == 2'd3) && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      err_sel_q  <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      mem_q      <= mem_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      err_sel_q  <= err_sel_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_demux3_stream.sv
// tb_demux3_stream: scenario tasks drive demux3_stream. A negedge monitor
// pops an expected-word queue for every delivered word.
module tb_demux3_stream;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [1:0]   in_sel;
  logic         y0_valid, y1_valid, y2_valid;
  logic         y0_ready, y1_ready, y2_ready;
  logic [W-1:0] y0, y1, y2;
  logic         err_sel;
  logic [7:0]   drop_cnt;

  int checks = 0;
  int errors = 0;
  int cycles_used = 0;
  logic [W+1:0] exp_q[$];

  demux3_stream #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .y0_valid(y0_valid), .y1_valid(y1_valid), .y2_valid(y2_valid),
    .y0_ready(y0_ready), .y1_ready(y1_ready), .y2_ready(y2_ready),
    .y0(y0), .y1(y1), .y2(y2),
    .err_sel(err_sel), .drop_cnt(drop_cnt)
  );

  // Clock: period 10, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Monitor: at the falling edge, a valid&&ready channel transfers on the
  // next rising edge; compare it against the front of the expected queue.
  always @(negedge clk) begin
    logic         v [3];
    logic         r [3];
    logic [W-1:0] d [3];
    logic [W+1:0] e;
    v[0] = y0_valid; v[1] = y1_valid; v[2] = y2_valid;
    r[0] = y0_ready; r[1] = y1_ready; r[2] = y2_ready;
    d[0] = y0; d[1] = y1; d[2] = y2;
    if (rst_n === 1'b1) begin
      if ((int'(v[0]) + int'(v[1]) + int'(v[2])) > 1) begin
        checks++; errors++;
        $display("FAIL onehot_valid: valids=%b%b%b, required at most one", v[2], v[1], v[0]);
      end
      if (v[0] || v[1] || v[2]) begin
        checks++;
        if (!(y0 === y1 && y1 === y2)) begin
          errors++;
          $display("FAIL data_broadcast: y0=%h y1=%h y2=%h, required all equal", y0, y1, y2);
        end
      end
      for (int k = 0; k < 3; k++) begin
        if (v[k] && r[k]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word: ch=%0d data=%h, required no word", k, d[k]);
          end else begin
            e = exp_q.pop_front();
            if ({2'(k), d[k]} !== e) begin
              errors++;
              $display("FAIL scoreboard: got ch=%0d data=%h, required ch=%0d data=%h",
                       k, d[k], e[W+1:W], e[W-1:0]);
            end
          end
        end
      end
    end
  end

  // Driver: present a word and hold it until accepted (bounded)
  task automatic send(input logic [1:0] s, input logic [W-1:0] d);
    int   n;
    logic acc;
    in_valid = 1'b1;
    in_sel   = s;
    in_data  = d;
    n = 0;
    do begin
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    cycles_used += n;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: word %h sel %0d not accepted in %0d cycles", d, s, n);
    end else if (s != 2'd3) begin
      exp_q.push_back({s, d});
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for all expected words to be delivered
  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d words outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = '0;
    y0_ready = 1'b1; y1_ready = 1'b1; y2_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, y0_valid, y1_valid, y2_valid, err_sel} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: ready/valids/err=%b, required 10000",
               {in_ready, y0_valid, y1_valid, y2_valid, err_sel});
    end
    checks++;
    if ({y0, y1, y2, drop_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_data: y0=%h y1=%h y2=%h drop=%h, required all 0", y0, y1, y2, drop_cnt);
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h3A;
    #1;
    checks++;
    if (y0_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_comb_path: y0_valid=%b before edge, required 0", y0_valid);
    end
    send(2'd0, 8'h3A);
    checks++;
    if (!(y0_valid === 1'b1 && y0 === 8'h3A && y1_valid === 1'b0)) begin
      errors++;
      $display("FAIL basic_y0: y0_valid=%b y0=%h, required 1 3a", y0_valid, y0);
    end
    send(2'd1, 8'h5F);
    checks++;
    if (!(y1_valid === 1'b1 && y1 === 8'h5F && y0_valid === 1'b0)) begin
      errors++;
      $display("FAIL basic_y1: y1_valid=%b y1=%h, required 1 5f", y1_valid, y1);
    end
    send(2'd2, 8'h80);
    checks++;
    if (!(y2_valid === 1'b1 && y2 === 8'h80 && y1_valid === 1'b0)) begin
      errors++;
      $display("FAIL basic_y2: y2_valid=%b y2=%h, required 1 80", y2_valid, y2);
    end
    idle();
    drain("basic");
  endtask

  task automatic test_backpressure();
    y1_ready = 1'b0;
    send(2'd1, 8'h11);
    send(2'd0, 8'h22);
    idle();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: in_ready=%b, required 0", in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (!(y1_valid === 1'b1 && y1 === 8'h11 && y0_valid === 1'b0 && in_ready === 1'b0)) begin
        errors++;
        $display("FAIL bp_stable: y1_valid=%b y1=%h y0_valid=%b in_ready=%b, required 1 11 0 0",
                 y1_valid, y1, y0_valid, in_ready);
      end
    end
    y1_ready = 1'b1;
    send(2'd2, 8'h33);
    idle();
    drain("bp");
  endtask

  task automatic test_invalid_sel();
    send(2'd3, 8'hAA);
    checks++;
    if ({y0_valid, y1_valid, y2_valid, err_sel} !== 4'b0001 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL inv_push: valids=%b err=%b drop=%0d, required 000 1 0",
               {y0_valid, y1_valid, y2_valid}, err_sel, drop_cnt);
    end
    send(2'd0, 8'h55);
    idle();
    checks++;
    if (!(drop_cnt === 8'd1 && y0_valid === 1'b1 && y0 === 8'h55)) begin
      errors++;
      $display("FAIL inv_follow: drop=%0d y0_valid=%b y0=%h, required 1 1 55", drop_cnt, y0_valid, y0);
    end
    drain("inv");
  endtask

  task automatic test_back_to_back();
    logic [1:0]   s;
    logic [W-1:0] d;
    cycles_used = 0;
    for (int i = 0; i < 40; i++) begin
      s = (i % 2 == 0) ? 2'd0 : 2'd1;
      d = W'($urandom_range(0, 255));
      send(s, d);
    end
    idle();
    checks++;
    if (cycles_used != 40) begin
      errors++;
      $display("FAIL stream_rate: %0d cycles for 40 words, required 40", cycles_used);
    end
    drain("stream");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 260; i++) begin
      send(2'd3, W'(i));
    end
    idle();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (!(drop_cnt === 8'hFF && err_sel === 1'b1)) begin
      errors++;
      $display("FAIL saturate: drop=%h err=%b, required ff 1", drop_cnt, err_sel);
    end
  endtask

  task automatic test_reset_mid();
    y0_ready = 1'b0; y1_ready = 1'b0; y2_ready = 1'b0;
    send(2'd0, 8'h01);
    send(2'd1, 8'h02);
    idle();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rm_full: in_ready=%b, required 0", in_ready);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, y0_valid, y1_valid, y2_valid, err_sel} !== 5'b10000 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rm_async: ready/valids/err=%b drop=%h, required 10000 00",
               {in_ready, y0_valid, y1_valid, y2_valid, err_sel}, drop_cnt);
    end
    exp_q.delete();
    #1 rst_n = 1'b1;
    y0_ready = 1'b1; y1_ready = 1'b1; y2_ready = 1'b1;
    checks++;
    if ({y0_valid, y1_valid, y2_valid, in_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL rm_empty: valids=%b in_ready=%b, required 000 1",
               {y0_valid, y1_valid, y2_valid}, in_ready);
    end
    send(2'd2, 8'h77);
    idle();
    checks++;
    if (!(y2_valid === 1'b1 && y2 === 8'h77 && cycles_used >= 0)) begin
      errors++;
      $display("FAIL rm_first_push: y2_valid=%b y2=%h, required 1 77", y2_valid, y2);
    end
    drain("rm");
    @(posedge clk); #1;
    checks++;
    if ({y0_valid, y1_valid, y2_valid} !== 3'b000 || y0 !== '0) begin
      errors++;
      $display("FAIL rm_idle: valids=%b y0=%h, required 000 00", {y0_valid, y1_valid, y2_valid}, y0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_invalid_sel();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
